regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised, resettable successor to the 16x32 register bank.
- Two registered read ports and one write port; depth and width are generic.
- Adds write-to-read bypass, optional hardwired zero register, and a per-register pending (scoreboard) bit so the decode stage can detect RAW hazards.
- Sits between decode (reads, reservations) and writeback (writes) in the RISC pipeline.

Parameters:
- WIDTH, 32, data width of each register.
- NUM_REGS, 16, number of registers; power of two, ≥2.
- ADDR_WIDTH, 4, register address width; must equal clog2(NUM_REGS).
- ZERO_REG, 1: register 0 always reads 0; writes and reservations to it are ignored. 0: register 0 is ordinary.
- RESET_VALUE, 0, value loaded into every register on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd1_en  in  1  read request, port 1.
- rd1_addr  in  ADDR_WIDTH  read address, port 1.
- rd1_data  out  WIDTH  registered read data, port 1.
- rd1_valid  out  1  rd1_data is fresh and hazard-free.
- rd1_hazard  out  1  last accepted port-1 read hit a pending register.
- rd2_en, rd2_addr, rd2_data, rd2_valid, rd2_hazard  same as port 1, for port 2.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  WIDTH  write data.
- rsv_en  in  1  mark a destination register pending.
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- pending  out  NUM_REGS  scoreboard bit vector, registered.
- pending_cnt  out  ADDR_WIDTH+1  number of set pending bits.

Behaviour:
- Reset (async, rst=1): all registers = RESET_VALUE; pending = 0; pending_cnt = 0; rdX_data = 0; rdX_valid = 0; rdX_hazard = 0. Effective immediately, including mid-operation; pending operations are discarded.
- Write: at the edge with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0. No effect when ZERO_REG=1 and wr_addr=0.
- Read latency: 1 cycle. At an edge with rdX_en=1:
  - rdX_data <= value of reg[rdX_addr].
  - rdX_valid <= 1 when the value is not pending, else 0.
  - rdX_hazard <= the inverse of rdX_valid.
- Idle read: at an edge with rdX_en=0, rdX_data holds its previous value and rdX_valid = rdX_hazard = 0. Outputs are never tristated.
- Bypass: if wr_en=1 and wr_addr=rdX_addr in the same cycle as an accepted read:
  - rdX_data <= wr_data.
  - rdX_valid <= 1 and rdX_hazard <= 0, regardless of the pending bit.
- Zero register: when ZERO_REG=1 and rdX_addr=0, rdX_data <= 0 and rdX_valid <= 1. Bypass does not apply.
- Reserve: rsv_en=1 sets pending[rsv_addr] at the edge.
  - Setting an already-set bit is a no-op; pending_cnt is unchanged.
  - Ignored when ZERO_REG=1 and rsv_addr=0.
- Simultaneous reserve and write to the same address: the reserve wins, so pending stays or becomes 1 (a new producer has issued). The write data is still stored.
- Same-cycle read by a reserve: a read in the same cycle as a reserve to its address sees the old pending value (reserve takes effect next cycle).
- Both read ports may target the same register; each port behaves independently.
- pending_cnt is a counter, not a popcount:
  - +1 on a reserve that sets a clear bit.
  - −1 on a write that clears a set bit not being re-reserved in that cycle.
  - Net 0 when both events hit different addresses with the above effects.
  - It cannot exceed NUM_REGS or go below 0.
  - Invariant: pending_cnt == popcount(pending) at all times; the bench checks this.
- Out-of-range addresses cannot occur because ADDR_WIDTH = clog2(NUM_REGS).

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/NUM_REGS constants.
  - clog2 function.
  - constant ZERO_ADDR = 0.
- One sub-module, regfile_read_port, instantiated twice. It holds the read-select, bypass, zero-register and valid/hazard output registers.
- Storage array, scoreboard and pending_cnt live in the top module.

Test Plan:
- Reset then read all 16 registers on both ports → every rdX_data = 0 one cycle after rdX_en, rdX_valid = 1, pending = 0, pending_cnt = 0.
- Write reg5 = 0xDEADBEEF, next cycle read port1 addr5 and port2 addr5 → both rdX_data = 0xDEADBEEF, valid = 1; write reg0 = 0x1234 then read addr0 → 0.
- Same cycle: wr_en reg7 = 0xA5A5A5A5 with rd1_addr = 7 → next cycle rd1_data = 0xA5A5A5A5, rd1_valid = 1 (bypass).
- Reserve reg3, next cycle read reg3 → rd1_hazard = 1, rd1_valid = 0, pending[3] = 1, pending_cnt = 1. Then write reg3 = 0x55 → pending[3] = 0, pending_cnt = 0, subsequent read returns 0x55 valid.
- Same cycle reserve reg9 and write reg9 = 0x77 → pending[9] = 1, reg9 = 0x77, pending_cnt = 1. Reserve reg4 while writing reg9 (pending) → pending_cnt stays 1.
- Reserve regs 1–6, assert rst mid-cycle (asynchronously) → pending = 0, pending_cnt = 0, all registers = RESET_VALUE, outputs 0 before the next clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int ZERO_ADDR        = 0;

  // Smallest r such that 2**r >= value; used to size register addresses.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: register select, write bypass, hardwired zero and
// valid/hazard flags. Instantiated once per read port by the top.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = clog2(DEFAULT_NUM_REGS),
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [WIDTH-1:0]      regs [NUM_REGS],
  input  logic [NUM_REGS-1:0]   pending,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  rd_hazard
);

  // Handshake: a read is accepted at every edge with rd_en=1 (no back-pressure).
  // One cycle later exactly one of rd_valid/rd_hazard is high; rd_valid means
  // rd_data is current and safe to consume, rd_hazard means the register still
  // awaits its producer and decode must retry. Both are low after an idle edge,
  // while rd_data keeps the last value returned.
  logic is_zero;
  logic is_bypass;

  assign is_zero   = ZERO_REG && (rd_addr == ADDR_WIDTH'(ZERO_ADDR));
  assign is_bypass = wr_en && (wr_addr == rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_hazard <= 1'b0;
    end else if (rd_en) begin
      if (is_zero) begin
        rd_data   <= '0;
        rd_valid  <= 1'b1;
        rd_hazard <= 1'b0;
      end else if (is_bypass) begin
        // The writeback value is the newest producer, so the pending bit is moot.
        rd_data   <= wr_data;
        rd_valid  <= 1'b1;
        rd_hazard <= 1'b0;
      end else begin
        rd_data   <= regs[rd_addr];
        rd_valid  <= ~pending[rd_addr];
        rd_hazard <= pending[rd_addr];
      end
    end else begin
      rd_valid  <= 1'b0;
      rd_hazard <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, one write port, write bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               NUM_REGS    = DEFAULT_NUM_REGS,
  parameter int               ADDR_WIDTH  = clog2(DEFAULT_NUM_REGS),
  parameter bit               ZERO_REG    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd1_en,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [WIDTH-1:0]      rd1_data,
  output logic                  rd1_valid,
  output logic                  rd1_hazard,
  input  logic                  rd2_en,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic [WIDTH-1:0]      rd2_data,
  output logic                  rd2_valid,
  output logic                  rd2_hazard,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [NUM_REGS-1:0]   pending,
  output logic [ADDR_WIDTH:0]   pending_cnt
);

  if (ADDR_WIDTH != clog2(NUM_REGS)) begin : g_bad_addr_width
    $error("regfile_scoreboard: ADDR_WIDTH must equal clog2(NUM_REGS)");
  end

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending_next;
  logic                wr_eff;
  logic                rsv_eff;
  logic                cnt_inc;
  logic                cnt_dec;

  assign wr_eff  = wr_en  && !(ZERO_REG && (wr_addr  == ADDR_WIDTH'(ZERO_ADDR)));
  assign rsv_eff = rsv_en && !(ZERO_REG && (rsv_addr == ADDR_WIDTH'(ZERO_ADDR)));

  // Write clears first, reserve sets last: a same-address reserve wins because
  // it marks a newer producer than the one being written back.
  always_comb begin
    pending_next = pending;
    if (wr_eff) begin
      pending_next[wr_addr] = 1'b0;
    end
    if (rsv_eff) begin
      pending_next[rsv_addr] = 1'b1;
    end
  end

  // Counter tracks only real 0->1 and 1->0 transitions so it mirrors popcount.
  assign cnt_inc = rsv_eff && !pending[rsv_addr];
  assign cnt_dec = wr_eff && pending[wr_addr] && !(rsv_eff && (rsv_addr == wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      if (wr_eff) begin
        regs[wr_addr] <= wr_data;
      end
      pending <= pending_next;
      if (cnt_inc && !cnt_dec) begin
        pending_cnt <= pending_cnt + 1'b1;
      end else if (cnt_dec && !cnt_inc) begin
        pending_cnt <= pending_cnt - 1'b1;
      end
    end
  end

  regfile_read_port #(
    .WIDTH      (WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rd1 (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd1_en),
    .rd_addr   (rd1_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs      (regs),
    .pending   (pending),
    .rd_data   (rd1_data),
    .rd_valid  (rd1_valid),
    .rd_hazard (rd1_hazard)
  );

  regfile_read_port #(
    .WIDTH      (WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_rd2 (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd2_en),
    .rd_addr   (rd2_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs      (regs),
    .pending   (pending),
    .rd_data   (rd2_data),
    .rd_valid  (rd2_valid),
    .rd_hazard (rd2_hazard)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: array/bit-set model, per-cycle compare
// of every output, and literal expectations for the key scenarios.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          rd1_en, rd2_en, wr_en, rsv_en;
  logic [AW-1:0] rd1_addr, rd2_addr, wr_addr, rsv_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd1_data, rd2_data;
  logic          rd1_valid, rd1_hazard, rd2_valid, rd2_hazard;
  logic [N-1:0]  pending;
  logic [AW:0]   pending_cnt;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .rd1_en      (rd1_en),
    .rd1_addr    (rd1_addr),
    .rd1_data    (rd1_data),
    .rd1_valid   (rd1_valid),
    .rd1_hazard  (rd1_hazard),
    .rd2_en      (rd2_en),
    .rd2_addr    (rd2_addr),
    .rd2_data    (rd2_data),
    .rd2_valid   (rd2_valid),
    .rd2_hazard  (rd2_hazard),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [W-1:0] d1;
    logic         v1;
    logic         h1;
    logic [W-1:0] d2;
    logic         v2;
    logic         h2;
    logic [N-1:0] pend;
    logic [AW:0]  cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  m_regs [N];
  bit            m_pend [N];
  logic [W-1:0]  m_d1, m_d2;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_d1 = '0;
    m_d2 = '0;
  endtask

  function automatic int pend_count();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Outcome of one read request from the rules: zero register, then bypass,
  // then stored value gated by the scoreboard bit as it was before this edge.
  task automatic model_read(input logic en, input logic [AW-1:0] a, input logic [W-1:0] prev,
                            input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                            output logic [W-1:0] d, output logic v, output logic h);
    if (!en) begin
      d = prev; v = 1'b0; h = 1'b0;
    end else if (a == 0) begin
      d = '0; v = 1'b1; h = 1'b0;
    end else if (we && wa == a) begin
      d = wd; v = 1'b1; h = 1'b0;
    end else begin
      d = m_regs[a]; v = !m_pend[a]; h = m_pend[a];
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic r1e, input logic [AW-1:0] r1a,
                          input logic r2e, input logic [AW-1:0] r2a,
                          input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                          input logic re, input logic [AW-1:0] ra);
    exp_t e;
    rd1_en = r1e; rd1_addr = r1a; rd2_en = r2e; rd2_addr = r2a;
    wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
    model_read(r1e, r1a, m_d1, we, wa, wd, e.d1, e.v1, e.h1);
    model_read(r2e, r2a, m_d2, we, wa, wd, e.d2, e.v2, e.h2);
    @(posedge clk);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (re && ra != 0) m_pend[ra] = 1'b1;
    m_d1 = e.d1;
    m_d2 = e.d2;
    e.pend = pend_vec();
    e.cnt  = (AW+1)'(pend_count());
    exp_q.push_back(e);
    #1;
    rd1_en = 1'b0; rd2_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic rd_both(input logic [AW-1:0] a);
    do_cycle(1, a, 1, a, 0, 0, '0, 0, 0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    do_cycle(0, 0, 0, 0, 1, a, d, 0, 0);
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    do_cycle(0, 0, 0, 0, 0, 0, '0, 1, a);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(pending_cnt) != $countones(pending)) begin
        failures++;
        $display("FAIL cnt_invariant: pending_cnt=%0d popcount=%0d at %0t",
                 pending_cnt, $countones(pending), $time);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd1_data", rd1_data, e.d1);
        check("rd1_valid", W'(rd1_valid), W'(e.v1));
        check("rd1_hazard", W'(rd1_hazard), W'(e.h1));
        check("rd2_data", rd2_data, e.d2);
        check("rd2_valid", W'(rd2_valid), W'(e.v2));
        check("rd2_hazard", W'(rd2_hazard), W'(e.h2));
        check("pending", W'(pending), W'(e.pend));
        check("pending_cnt", W'(pending_cnt), W'(e.cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    rd1_en = 0; rd2_en = 0; wr_en = 0; rsv_en = 0;
    rd1_addr = 0; rd2_addr = 0; wr_addr = 0; rsv_addr = 0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1_data", rd1_data, 32'h0);
    check("reset_rd1_valid", W'(rd1_valid), 32'h0);
    check("reset_pending", W'(pending), 32'h0);
    check("reset_cnt", W'(pending_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // All registers read zero on both ports after reset.
    for (int i = 0; i < N; i++) begin
      rd_both(AW'(i));
      check("init_rd1", rd1_data, 32'h0);
      check("init_rd2_valid", W'(rd2_valid), 32'h1);
    end

    wr(5, 32'hDEADBEEF);
    rd_both(5);
    check("r5_rd1", rd1_data, 32'hDEADBEEF);
    check("r5_rd2", rd2_data, 32'hDEADBEEF);
    check("r5_valid", W'(rd1_valid & rd2_valid), 32'h1);

    // Zero register: write ignored, same-cycle read not bypassed.
    do_cycle(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
    check("zero_nobypass", rd1_data, 32'h0);
    rd_both(0);
    check("zero_read", rd2_data, 32'h0);
    check("zero_valid", W'(rd2_valid), 32'h1);

    // Bypass.
    do_cycle(1, 7, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0);
    check("bypass_data", rd1_data, 32'hA5A5A5A5);
    check("bypass_valid", W'(rd1_valid), 32'h1);

    // Reserve reg3; a same-cycle read sees the old (clear) bit.
    do_cycle(0, 0, 1, 3, 0, 0, '0, 1, 3);
    check("rsv_samecycle_valid", W'(rd2_valid), 32'h1);
    do_cycle(1, 3, 0, 0, 0, 0, '0, 0, 0);
    check("haz_hazard", W'(rd1_hazard), 32'h1);
    check("haz_valid", W'(rd1_valid), 32'h0);
    check("haz_pending", W'(pending), 32'h0008);
    check("haz_cnt", W'(pending_cnt), 32'h1);
    wr(3, 32'h55);
    check("clr_pending", W'(pending), 32'h0);
    check("clr_cnt", W'(pending_cnt), 32'h0);
    rd_both(3);
    check("clr_read", rd1_data, 32'h55);
    check("clr_valid", W'(rd1_valid), 32'h1);

    // Bypass overrides a pending bit.
    rsv(3);
    do_cycle(1, 3, 1, 3, 1, 3, 32'h66, 0, 0);
    check("byp_pend_valid", W'(rd1_valid), 32'h1);
    check("byp_pend_data", rd2_data, 32'h66);

    // Reserve and write same address: reserve wins, data stored.
    do_cycle(0, 0, 0, 0, 1, 9, 32'h77, 1, 9);
    check("rw9_pending", W'(pending), 32'h0200);
    check("rw9_cnt", W'(pending_cnt), 32'h1);
    do_cycle(0, 0, 0, 0, 1, 9, 32'h77, 1, 4);
    check("swap_cnt", W'(pending_cnt), 32'h1);
    check("swap_pending", W'(pending), 32'h0010);
    rd_both(9);
    check("r9_data", rd1_data, 32'h77);
    rsv(4);
    check("rsv_again_cnt", W'(pending_cnt), 32'h1);
    rsv(0);
    check("rsv_zero_ignored", W'(pending), 32'h0010);

    // Reserve 1..6 then asynchronous reset between edges.
    for (int i = 1; i <= 6; i++) rsv(AW'(i));
    check("pre_rst_cnt", W'(pending_cnt), 32'h6);
    rd_both(9);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_reset();
    check("async_pending", W'(pending), 32'h0);
    check("async_cnt", W'(pending_cnt), 32'h0);
    check("async_rd1_data", rd1_data, 32'h0);
    check("async_rd2_valid", W'(rd2_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_both(AW'(i));
      check("post_rst_read", rd2_data, 32'h0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
